hazard_scoreboard: RTL and testbench

- Next-generation hazard unit for the 5-stage RISC-V core (F, D, E, M, W).
- Keeps the existing M/W forwarding and load-use stall.
- Adds three features:
  - a register scoreboard for the multi-cycle multiply/divide unit (MDU), with an outstanding-op limit;
  - a data-memory wait FSM with timeout;
  - a saturating stall-cycle performance counter.
- Sits beside the datapath and drives all stall, flush and forward controls.

---
 rtl/hazard_scoreboard.sv | 188 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: M/W forwarding, load-use stall, MDU register
// scoreboard with in-flight limit, data-memory wait FSM with timeout, stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_SLOTS   = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int PERF_CNT_W  = 32,
    parameter int ZERO_REG    = 1,
    localparam int NUM_REGS   = 2**REG_ADDR_W,
    localparam int OUT_W      = $clog2(MDU_SLOTS + 1),
    localparam int TMR_W      = $clog2(MEM_TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  RegWriteE,
    input  logic                  ResultSrcE_zero,
    input  logic                  MduStartE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic                  DmemReqM,
    input  logic                  DmemReadyM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    input  logic                  MduDoneX,
    input  logic [REG_ADDR_W-1:0] MduRdX,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  FlushW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  MemFault,
    output logic [PERF_CNT_W-1:0] StallCycles,
    output logic [NUM_REGS-1:0]   o_dbg_sb,
    output logic [OUT_W-1:0]      o_dbg_outstanding,
    output logic                  o_dbg_mem_wait
);

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

    mem_state_t            r_mem_state;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_mem_fault;
    logic [NUM_REGS-1:0]   r_sb;
    logic [OUT_W-1:0]      r_outstanding;
    logic [PERF_CNT_W-1:0] r_stall_cnt;

    logic                  w_lw_stall, w_sb_stall, w_mdu_full, w_mem_stall;
    logic                  w_issue, w_clear;
    logic [NUM_REGS-1:0]   w_sb_next;

    // Register 0 is excluded from every hazard check when hardwired.
    function automatic logic nz(input logic [REG_ADDR_W-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd_m, input logic we_m,
                                       input logic [REG_ADDR_W-1:0] rd_w, input logic we_w);
        if (rs == rd_m && we_m && nz(rs)) return 2'b10;
        if (rs == rd_w && we_w && nz(rs)) return 2'b01;
        return 2'b00;
    endfunction

    assign ForwardAE = fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign w_lw_stall  = ResultSrcE_zero && RegWriteE && nz(RdE) && (Rs1D == RdE || Rs2D == RdE);
    assign w_sb_stall  = (r_sb[Rs1D] && nz(Rs1D)) || (r_sb[Rs2D] && nz(Rs2D)) ||
                         (RegWriteD && r_sb[RdD] && nz(RdD));
    assign w_mdu_full  = MduStartE && (r_outstanding == OUT_W'(MDU_SLOTS)) && !MduDoneX;
    assign w_mem_stall = DmemReqM && !DmemReadyM &&
                         (r_mem_state == MEM_IDLE || r_timer < TMR_LAST);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (w_mdu_full) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall || w_sb_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // A done for a register that is not pending is stale and must not touch the count.
    assign w_issue = MduStartE && RegWriteE && nz(RdE) && !StallE && !FlushE && !w_mem_stall;
    assign w_clear = MduDoneX && nz(MduRdX) && r_sb[MduRdX];

    always_comb begin
        w_sb_next = r_sb;
        if (w_clear) w_sb_next[MduRdX] = 1'b0;
        if (w_issue) w_sb_next[RdE] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb          <= '0;
            r_outstanding <= '0;
        end else begin
            r_sb          <= w_sb_next;
            r_outstanding <= r_outstanding + OUT_W'(w_issue) - OUT_W'(w_clear);
        end
    end

    // Timer counts wait cycles; at TMR_LAST the stall is dropped and a fault pulse follows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_state <= MEM_IDLE;
            r_timer     <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_mem_fault <= 1'b0;
            case (r_mem_state)
                MEM_IDLE: begin
                    if (DmemReqM && !DmemReadyM) begin
                        r_mem_state <= MEM_WAIT;
                        r_timer     <= TMR_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!DmemReqM || DmemReadyM) begin
                        r_mem_state <= MEM_IDLE;
                        r_timer     <= '0;
                    end else if (r_timer == TMR_LAST) begin
                        r_mem_state <= MEM_IDLE;
                        r_timer     <= '0;
                        r_mem_fault <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_mem_state <= MEM_IDLE;
                    r_timer     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (StallF && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
        end
    end

    assign MemFault          = r_mem_fault;
    assign StallCycles       = r_stall_cnt;
    assign o_dbg_sb          = r_sb;
    assign o_dbg_outstanding = r_outstanding;
    assign o_dbg_mem_wait    = (r_mem_state == MEM_WAIT);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected control vectors are queued when a step
// is driven and compared at the following negedge; stall counter tracked by a small model.
module tb_hazard_scoreboard;

    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int PW  = 5;
    localparam int CW  = 13;
    localparam int CNT_MAX = 31;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, MduRdX;
    logic          RegWriteD, RegWriteE, ResultSrcE_zero, MduStartE, PCSrcE;
    logic          RegWriteM, DmemReqM, DmemReadyM, RegWriteW, MduDoneX;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemFault;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [PW-1:0] StallCycles;
    logic [NR-1:0] o_dbg_sb;
    logic [1:0]    o_dbg_outstanding;
    logic          o_dbg_mem_wait;

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall_cnt = 0;
    logic [CW-1:0] exp_q[$];

    hazard_scoreboard #(
        .REG_ADDR_W(AW), .MDU_SLOTS(2), .MEM_TIMEOUT(4), .PERF_CNT_W(PW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE_zero(ResultSrcE_zero), .MduStartE(MduStartE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW), .MduDoneX(MduDoneX), .MduRdX(MduRdX),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemFault(MemFault),
        .StallCycles(StallCycles), .o_dbg_sb(o_dbg_sb),
        .o_dbg_outstanding(o_dbg_outstanding), .o_dbg_mem_wait(o_dbg_mem_wait)
    );

    always #5 clk = ~clk;

    wire [CW-1:0] act_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                             ForwardAE, ForwardBE, MemFault};

    function automatic logic [CW-1:0] ctl(input logic sf, sd, se, sm, fd, fe, fm, fw,
                                          input logic [1:0] fa, fb, input logic mf);
        return {sf, sd, se, sm, fd, fe, fm, fw, fa, fb, mf};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0;
        ResultSrcE_zero = 1'b0; MduStartE = 1'b0; PCSrcE = 1'b0;
        RdM = '0; RegWriteM = 1'b0; DmemReqM = 1'b0; DmemReadyM = 1'b0;
        RdW = '0; RegWriteW = 1'b0; MduDoneX = 1'b0; MduRdX = '0;
    endtask

    // One cycle: inputs already driven; compare at negedge, advance model at posedge.
    task automatic step(input string tag, input logic [CW-1:0] e);
        logic [CW-1:0] exp_v;
        exp_q.push_back(e);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        chk({tag, "/ctl"}, 32'(act_ctl), 32'(exp_v));
        chk({tag, "/cnt"}, 32'(StallCycles), 32'(exp_stall_cnt));
        @(posedge clk);
        if (e[CW-1] && exp_stall_cnt < CNT_MAX) exp_stall_cnt++;
        #1;
    endtask

    task automatic mdu_issue(input logic [AW-1:0] rd);
        MduStartE = 1'b1; RegWriteE = 1'b1; RdE = rd;
    endtask

    initial begin
        logic [CW-1:0] none, sb_hold, mdu_hold, mem_hold, ld_hold;
        none     = ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,0);
        sb_hold  = ctl(1,1,0,0,0,1,0,0,2'b00,2'b00,0);
        ld_hold  = sb_hold;
        mdu_hold = ctl(1,1,1,0,0,0,1,0,2'b00,2'b00,0);
        mem_hold = ctl(1,1,1,1,0,0,0,1,2'b00,2'b00,0);

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sb", 32'(o_dbg_sb), 32'd0);
        chk("rst_out", 32'(o_dbg_outstanding), 32'd0);
        chk("rst_fsm", 32'(o_dbg_mem_wait), 32'd0);
        chk("rst_cnt", 32'(StallCycles), 32'd0);
        chk("rst_fault", 32'(MemFault), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // MDU op to x5, dependent instruction waits until the cycle after done
        idle(); mdu_issue(5); Rs1D = 1; Rs2D = 2; RdD = 8; RegWriteD = 1'b1;
        step("t1_issue", none);
        chk("t1_out1", 32'(o_dbg_outstanding), 32'd1);
        chk("t1_sb5", 32'(o_dbg_sb), 32'h0000_0020);
        idle(); Rs1D = 5; Rs2D = 1; RdD = 9; RegWriteD = 1'b1; MduRdX = 5;
        for (int i = 1; i <= 6; i++) begin
            MduDoneX = (i == 6);
            step("t1_wait", sb_hold);
        end
        chk("t1_out0", 32'(o_dbg_outstanding), 32'd0);
        chk("t1_sb0", 32'(o_dbg_sb), 32'd0);
        MduDoneX = 1'b0;
        step("t1_go", none);

        // Three back-to-back MDU ops with two slots
        idle(); mdu_issue(3); step("t2_x3", none);
        mdu_issue(4); step("t2_x4", none);
        chk("t2_out2", 32'(o_dbg_outstanding), 32'd2);
        mdu_issue(6); step("t2_full", mdu_hold);
        PCSrcE = 1'b1; step("t2_full_pc", mdu_hold);
        PCSrcE = 1'b0; MduDoneX = 1'b1; MduRdX = 3; step("t2_swap", none);
        chk("t2_out_net", 32'(o_dbg_outstanding), 32'd2);
        chk("t2_sb46", 32'(o_dbg_sb), 32'h0000_0050);
        idle(); MduDoneX = 1'b1; MduRdX = 9; step("t2_stale", none);
        chk("t2_stale_out", 32'(o_dbg_outstanding), 32'd2);
        MduRdX = 4; step("t2_done4", none);
        MduRdX = 6; step("t2_done6", none);
        chk("t2_out0", 32'(o_dbg_outstanding), 32'd0);
        MduRdX = 6; step("t2_underflow", none);
        chk("t2_no_uflow", 32'(o_dbg_outstanding), 32'd0);
        chk("t2_sb0", 32'(o_dbg_sb), 32'd0);

        // Load-use on x7, then forwarding priority
        idle(); ResultSrcE_zero = 1'b1; RegWriteE = 1'b1; RdE = 7; Rs1D = 7;
        step("t3_lw", ld_hold);
        idle(); RdM = 7; RegWriteM = 1'b1; Rs1E = 7; Rs2E = 7; RdW = 7; RegWriteW = 1'b1;
        step("t3_fwd_mm", ctl(0,0,0,0,0,0,0,0,2'b10,2'b10,0));
        Rs2E = 8; RdW = 8;
        step("t3_fwd_mw", ctl(0,0,0,0,0,0,0,0,2'b10,2'b01,0));
        RegWriteM = 1'b0;
        step("t3_fwd_nw", ctl(0,0,0,0,0,0,0,0,2'b00,2'b01,0));
        idle(); ResultSrcE_zero = 1'b1; RegWriteE = 1'b1; RdE = 0; Rs1D = 0;
        step("t3_lw_x0", none);

        // Memory ready after three wait cycles
        idle(); DmemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DmemReadyM = (i == 3);
            step("t4_mem", (i < 3) ? mem_hold : none);
            if (i == 0) chk("t4_wait", 32'(o_dbg_mem_wait), 32'd1);
        end
        chk("t4_idle", 32'(o_dbg_mem_wait), 32'd0);

        // Timeout: stall spans the IDLE cycle plus timer 1..2, released at timer 3
        idle(); DmemReqM = 1'b1;
        for (int i = 0; i < 3; i++) step("t5_stall", mem_hold);
        step("t5_release", none);
        chk("t5_fsm_idle", 32'(o_dbg_mem_wait), 32'd0);
        idle();
        step("t5_fault", ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,1));
        step("t5_fault_end", none);

        // Priority and zero-register forwarding
        idle(); ResultSrcE_zero = 1'b1; RegWriteE = 1'b1; RdE = 7; Rs1D = 7; PCSrcE = 1'b1;
        step("t6_pc_lw", ctl(0,0,0,0,1,1,0,0,2'b00,2'b00,0));
        idle(); PCSrcE = 1'b1; DmemReqM = 1'b1;
        step("t6_pc_mem", mem_hold);
        PCSrcE = 1'b0; DmemReadyM = 1'b1;
        step("t6_mem_done", none);
        idle(); RegWriteM = 1'b1; RdM = 0; Rs1E = 0; RegWriteW = 1'b1; RdW = 0; Rs2E = 0;
        step("t6_x0_fwd", none);

        // WAW against a pending MDU destination; same-cycle set and clear
        idle(); mdu_issue(10); step("t7_issue", none);
        idle(); RegWriteD = 1'b1; RdD = 10; Rs1D = 1; Rs2D = 2;
        step("t7_waw", sb_hold);
        MduDoneX = 1'b1; MduRdX = 10; step("t7_waw_done", sb_hold);
        MduDoneX = 1'b0; step("t7_waw_go", none);
        idle(); mdu_issue(11); step("t7_x11", none);
        MduDoneX = 1'b1; MduRdX = 11; step("t7_setclr", none);
        chk("t7_set_wins", 32'(o_dbg_sb), 32'h0000_0800);
        chk("t7_out_net", 32'(o_dbg_outstanding), 32'd1);
        idle(); MduDoneX = 1'b1; MduRdX = 11; step("t7_clr", none);
        chk("t7_out0", 32'(o_dbg_outstanding), 32'd0);

        // Asynchronous reset with an MDU op in flight
        idle(); mdu_issue(12); step("t8_issue", none);
        chk("t8_out1", 32'(o_dbg_outstanding), 32'd1);
        idle(); #2 rst_n = 1'b0; #1;
        chk("t8_sb_clr", 32'(o_dbg_sb), 32'd0);
        chk("t8_out_clr", 32'(o_dbg_outstanding), 32'd0);
        chk("t8_cnt_clr", 32'(StallCycles), 32'd0);
        exp_stall_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        MduDoneX = 1'b1; MduRdX = 12; step("t8_late_done", none);
        chk("t8_out_still0", 32'(o_dbg_outstanding), 32'd0);

        // Stall counter saturation
        idle(); ResultSrcE_zero = 1'b1; RegWriteE = 1'b1; RdE = 7; Rs2D = 7;
        for (int i = 0; i < 35; i++) step("t9_sat", ld_hold);
        chk("t9_cnt_sat", 32'(StallCycles), 32'(CNT_MAX));
        idle(); step("t9_end", none);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
